bloom_window_builder: RTL



---
 rtl/bloom_window_builder_if.sv | 65 ++++++
 rtl/bloom_window_builder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bloom_window_builder_if.sv
// ---------------------------------------------------------------------------
// bloom_window_builder_if
//
// Purpose:
//   Bundles the byte-stream input and the look-ahead window output of the
//   bloom window builder into one interface.
//
// Signals:
//   data_i               stream byte
//   valid_i              data_i valid
//   startofpacket_i      first byte of a packet
//   endofpacket_i        last byte of a packet
//   ready_o              byte accepted when valid_i && ready_o
//   window_data_o        look-ahead window, index 0 = current position
//   window_valid_bytes_o number of valid window bytes, 0 = nothing presented
//   window_ready_i       downstream accepts the presented window
//   sop_err_cnt_o        saturating count of start-of-packet seen mid-packet
//
// Modports:
//   master  upstream source / downstream sink side (drives the stream bytes
//           and window_ready_i)
//   slave   the window builder itself
// ---------------------------------------------------------------------------
interface bloom_window_builder_if #(
   parameter int BYTE_W         = 8,
   parameter int MAX_STR_SIZE   = 20,
   parameter int ERR_CNT_W      = 16,
   parameter int MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE) + 1
);

   logic [BYTE_W-1:0]                    data_i;
   logic                                 valid_i;
   logic                                 startofpacket_i;
   logic                                 endofpacket_i;
   logic                                 ready_o;
   logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]  window_data_o;
   logic [MAX_STR_SIZE_W-1:0]            window_valid_bytes_o;
   logic                                 window_ready_i;
   logic [ERR_CNT_W-1:0]                 sop_err_cnt_o;

   modport master (
      output data_i,
      output valid_i,
      output startofpacket_i,
      output endofpacket_i,
      output window_ready_i,
      input  ready_o,
      input  window_data_o,
      input  window_valid_bytes_o,
      input  sop_err_cnt_o
   );

   modport slave (
      input  data_i,
      input  valid_i,
      input  startofpacket_i,
      input  endofpacket_i,
      input  window_ready_i,
      output ready_o,
      output window_data_o,
      output window_valid_bytes_o,
      output sop_err_cnt_o
   );

endinterface

// File: rtl/bloom_window_builder.sv
// ---------------------------------------------------------------------------
// bloom_window_builder
//
// Purpose:
//   Turns a packet-delimited byte stream (one byte per cycle) into the
//   sliding look-ahead window used by the bloom search engine. For every
//   byte position of a packet that still has at least MIN_STR_SIZE bytes
//   left, the next up-to-MAX_STR_SIZE bytes are presented together with a
//   count of how many of them are valid.
//
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset (synchronous release expected)
//   bus      bloom_window_builder_if.slave
//              in : data_i, valid_i, startofpacket_i, endofpacket_i,
//                   window_ready_i
//              out: ready_o, window_data_o, window_valid_bytes_o,
//                   sop_err_cnt_o
//
// Parameters:
//   BYTE_W          bits per byte
//   MAX_STR_SIZE    window length in bytes
//   MIN_STR_SIZE    shortest string searched; shorter tails are discarded
//   ERR_CNT_W       width of the start-of-packet error counter
//   MAX_STR_SIZE_W  width of the valid-byte count
// ---------------------------------------------------------------------------
module bloom_window_builder #(
   parameter int BYTE_W         = 8,
   parameter int MAX_STR_SIZE   = 20,
   parameter int MIN_STR_SIZE   = 3,
   parameter int ERR_CNT_W      = 16,
   parameter int MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   bloom_window_builder_if.slave  bus
);

   // FILL: packet open, still collecting bytes.
   // DRAIN: end-of-packet byte stored, remaining windows are being emitted.
   typedef enum logic {
      S_FILL  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   localparam logic [MAX_STR_SIZE_W-1:0] C_MAX = MAX_STR_SIZE_W'(MAX_STR_SIZE);
   localparam logic [MAX_STR_SIZE_W-1:0] C_MIN = MAX_STR_SIZE_W'(MIN_STR_SIZE);
   localparam logic [MAX_STR_SIZE_W-1:0] C_ONE = MAX_STR_SIZE_W'(1);

   state_t                               r_state;
   state_t                               w_stateNext;
   logic [MAX_STR_SIZE_W-1:0]            r_cnt;
   logic [MAX_STR_SIZE_W-1:0]            w_cntNext;
   logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]  r_buf;
   logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]  w_bufNext;
   logic [ERR_CNT_W-1:0]                 r_sopErrCnt;
   logic [ERR_CNT_W-1:0]                 w_sopErrCntNext;

   logic                                 w_present;
   logic                                 w_wx;
   logic                                 w_ready;
   logic                                 w_bx;

   // Handshake decode. A window is presented once the buffer is full while
   // the packet is still open, or during drain while the tail is still at
   // least MIN_STR_SIZE long. Because a window transfer frees a slot in the
   // same cycle, ready_o looks at window_ready_i combinationally so that a
   // full buffer can keep streaming one byte per cycle. Holding ready_o low
   // while rst_n_i is low keeps upstream from handing over bytes that the
   // reset would throw away.
   always_comb begin
      w_present = ((r_state == S_FILL)  && (r_cnt == C_MAX)) ||
                  ((r_state == S_DRAIN) && (r_cnt >= C_MIN));
      w_wx      = w_present && bus.window_ready_i;
      w_ready   = rst_n_i && (r_state == S_FILL) && ((r_cnt < C_MAX) || w_wx);
      w_bx      = bus.valid_i && w_ready;
   end

   // Next-state and datapath update. Ordering inside the cycle matters:
   // a window transfer shifts the buffer down first, then an accepted byte
   // lands in the first free slot of the already-shifted buffer. Shifting in
   // zeros at the top keeps every slot at or above cnt reading as zero, so
   // the window never exposes stale bytes of an earlier packet.
   //
   // A start-of-packet on a byte arriving while bytes are still held means
   // the previous packet lost its end marker: everything held is dropped,
   // the new byte becomes position 0, and the error counter bumps (sticking
   // at all-ones instead of wrapping).
   //
   // Once the drain tail is too short to search, the whole buffer is
   // cleared in a single cycle and the builder reopens for the next packet.
   always_comb begin
      w_stateNext     = r_state;
      w_cntNext       = r_cnt;
      w_bufNext       = r_buf;
      w_sopErrCntNext = r_sopErrCnt;

      if ((r_state == S_DRAIN) && (r_cnt < C_MIN)) begin
         w_stateNext = S_FILL;
         w_cntNext   = '0;
         w_bufNext   = '0;
      end else begin
         if (w_wx) begin
            w_bufNext = r_buf >> BYTE_W;
            w_cntNext = r_cnt - C_ONE;
         end

         if (w_bx) begin
            if (bus.startofpacket_i && (r_cnt != '0)) begin
               w_bufNext    = '0;
               w_bufNext[0] = bus.data_i;
               w_cntNext    = C_ONE;
               if (r_sopErrCnt != '1) begin
                  w_sopErrCntNext = r_sopErrCnt + ERR_CNT_W'(1);
               end
            end else begin
               for (int k = 0; k < MAX_STR_SIZE; k++) begin
                  if (w_cntNext == MAX_STR_SIZE_W'(k)) begin
                     w_bufNext[k] = bus.data_i;
                  end
               end
               w_cntNext = w_cntNext + C_ONE;
            end

            if (bus.endofpacket_i) begin
               w_stateNext = S_DRAIN;
            end
         end
      end
   end

   // State register. Reset clears everything immediately, which also drops
   // any windows still waiting to be drained.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= S_FILL;
         r_cnt       <= '0;
         r_buf       <= '0;
         r_sopErrCnt <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_cnt       <= w_cntNext;
         r_buf       <= w_bufNext;
         r_sopErrCnt <= w_sopErrCntNext;
      end
   end

   // Output drive. The window contents are simply the buffer; the count is
   // forced to zero whenever no window is being offered.
   assign bus.ready_o              = w_ready;
   assign bus.window_data_o        = r_buf;
   assign bus.window_valid_bytes_o = w_present ? r_cnt : '0;
   assign bus.sop_err_cnt_o        = r_sopErrCnt;

endmodule
